pipe_ctrl_chain: RTL and testbench
==================================

Name: pipe_ctrl_chain

Overview:
Parametrised multi-stage pipeline register chain for decoded control bundles, e.g. D→E→M→W in the MIPS core. Generalises the single-stage, single-stall control register. Adds:
- per-stage hold and flush with automatic bubble insertion;
- per-stage valid bits and a configurable bubble pattern;
- a saturating bubble counter;
- a sticky error flag for illegal hold patterns.

Parameters:
WIDTH, 8, width of one control bundle in bits
NSTAGE, 3, number of pipeline stages (≥1)
BUBBLE, {WIDTH{1'b0}}, control value loaded when a stage is bubbled or reset
CNTW, 16, width of bubble counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
in_ctrl  input  WIDTH  control bundle entering stage 0 (from decode)
in_valid  input  1  in_ctrl is a real instruction
hold  input  NSTAGE  hold[k]=1 freezes stage k
flush  input  NSTAGE  flush[k]=1 loads bubble into stage k
cnt_clr  input  1  synchronous clear of bubble counter
ctrl_o  output  NSTAGE*WIDTH  stage k bundle at bits [k*WIDTH +: WIDTH]
valid_o  output  NSTAGE  valid bit of each stage
bubble_cnt  output  CNTW  bubbles inserted since reset/clear, saturating
hold_err  output  1  sticky: illegal hold pattern seen

Behaviour:
- Async reset (reset==0): every stage ctrl=BUBBLE, valid_o=0, bubble_cnt=0, hold_err=0. Takes effect immediately, mid-operation included. Release is synchronous to the next clk edge.
- Source of stage k: src(0)=in_ctrl/in_valid; src(k)=stage k-1 contents for k≥1.
- Per-stage update at each rising edge, evaluated in priority order:
  1. flush[k]=1 → ctrl=BUBBLE, valid=0. Flush overrides hold.
  2. hold[k]=1 → keep current ctrl/valid.
  3. k≥1 and hold[k-1]=1 → ctrl=BUBBLE, valid=0 (auto-bubble behind a stalled stage).
  4. Otherwise → load src(k).
- Latency: in_ctrl appears on stage k after k+1 unstalled edges. No combinational path from inputs to outputs.
- A bubble event is any edge where rule 1 or 3 fires for some stage.
  - bubble_cnt increments by exactly 1 per edge with ≥1 bubble event, regardless of how many stages bubble.
  - bubble_cnt saturates at 2^CNTW-1 with no wrap.
  - cnt_clr=1 sets bubble_cnt=0 on that edge and takes priority over increment.
- Legal hold pattern: hold[k+1]=1 requires hold[k]=1 (downstream stall implies upstream stall).
  - Violation on an edge sets hold_err=1 until reset; flush does not excuse it.
  - Stage updates still follow rules 1–4 on a violating edge; the overwritten stage-k content is lost (documented, not prevented).
- Edge cases:
  - in_valid=0 with hold[0]=0: stage 0 loads in_ctrl with valid=0. This is not counted as a bubble.
  - NSTAGE=1: rule 3 never applies; hold_err is tied 0.
  - Every output comes directly from a flop.

Test Plan:
- Reset/flow (WIDTH=8, NSTAGE=3, BUBBLE=0): assert reset low mid-stream → all ctrl_o=0, valid_o=000 with no clock edge. Release, drive in_ctrl 0x11,0x22,0x33 with valid=1 → after edge 3, stage2=0x11, stage1=0x22, stage0=0x33, valid_o=111.
- Load-use stall: pipe full (0x11/0x22/0x33), in_ctrl=0x44, hold=001 for one cycle → stage0 stays 0x33, stage1=BUBBLE with valid=0, stage2=0x22, bubble_cnt=1. Next edge with hold=000 → stage0=0x44, stage1=0x33.
- Flush beats hold: hold=011, flush=010 → stage1=BUBBLE/valid=0, stage0 held, stage2=BUBBLE (auto-bubble), bubble_cnt +1 only, hold_err stays 0.
- Illegal hold: hold=010 for one edge → hold_err=1 and remains 1 after hold=000. Only reset clears it.
- Counter: CNTW=4, flush=001 for 20 consecutive edges → bubble_cnt saturates at 15. Then cnt_clr=1 with flush=001 on the same edge → bubble_cnt=0.
- Idle input: in_valid=0, in_ctrl=0xAA, no hold/flush → stage0=0xAA, valid_o[0]=0, bubble_cnt unchanged.

Source files
------------

// File: rtl/pipe_ctrl_chain.sv
// rtl/pipe_ctrl_chain.sv - multi-stage control-bundle pipeline with hold/flush, bubble counter and hold error flag
module pipe_ctrl_chain #(
  parameter int               WIDTH  = 8,
  parameter int               NSTAGE = 3,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNTW   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_ctrl,
  input  logic                      in_valid,
  input  logic [NSTAGE-1:0]         hold,
  input  logic [NSTAGE-1:0]         flush,
  input  logic                      cnt_clr,
  output logic [NSTAGE*WIDTH-1:0]   ctrl_o,
  output logic [NSTAGE-1:0]         valid_o,
  output logic [CNTW-1:0]           bubble_cnt,
  output logic                      hold_err
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [NSTAGE*WIDTH-1:0] ctrl_q, ctrl_d;
  logic [NSTAGE-1:0]       valid_q, valid_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    bubble_ev;
  logic                    hold_viol;

  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    bubble_ev = 1'b0;

    // Stage 0 takes its source from decode and has no upstream stage to stall it.
    if (flush[0]) begin
      ctrl_d[0 +: WIDTH] = BUBBLE;
      valid_d[0]         = 1'b0;
      bubble_ev          = 1'b1;
    end else if (!hold[0]) begin
      ctrl_d[0 +: WIDTH] = in_ctrl;
      valid_d[0]         = in_valid;
    end

    for (int k = 1; k < NSTAGE; k++) begin
      if (flush[k]) begin
        ctrl_d[k*WIDTH +: WIDTH] = BUBBLE;
        valid_d[k]               = 1'b0;
        bubble_ev                = 1'b1;
      end else if (hold[k]) begin
        ctrl_d[k*WIDTH +: WIDTH] = ctrl_q[k*WIDTH +: WIDTH];
        valid_d[k]               = valid_q[k];
      end else if (hold[k-1]) begin
        ctrl_d[k*WIDTH +: WIDTH] = BUBBLE;
        valid_d[k]               = 1'b0;
        bubble_ev                = 1'b1;
      end else begin
        ctrl_d[k*WIDTH +: WIDTH] = ctrl_q[(k-1)*WIDTH +: WIDTH];
        valid_d[k]               = valid_q[k-1];
      end
    end
  end

  generate
    if (NSTAGE > 1) begin : g_viol
      assign hold_viol = |(hold[NSTAGE-1:1] & ~hold[NSTAGE-2:0]);
    end else begin : g_no_viol
      assign hold_viol = 1'b0;
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (bubble_ev && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | hold_viol;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= {NSTAGE{BUBBLE}};
      valid_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign valid_o    = valid_q;
  assign bubble_cnt = cnt_q;
  assign hold_err   = err_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb/tb_pipe_ctrl_chain.sv - directed vector bench for pipe_ctrl_chain
module tb_pipe_ctrl_chain;

  localparam int WIDTH  = 8;
  localparam int NSTAGE = 3;
  localparam int CNTW   = 4;

  logic                    clk;
  logic                    reset;
  logic [WIDTH-1:0]        in_ctrl;
  logic                    in_valid;
  logic [NSTAGE-1:0]       hold;
  logic [NSTAGE-1:0]       flush;
  logic                    cnt_clr;
  logic [NSTAGE*WIDTH-1:0] ctrl_o;
  logic [NSTAGE-1:0]       valid_o;
  logic [CNTW-1:0]         bubble_cnt;
  logic                    hold_err;

  pipe_ctrl_chain #(
    .WIDTH (WIDTH),
    .NSTAGE(NSTAGE),
    .BUBBLE(8'h00),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_ctrl   (in_ctrl),
    .in_valid  (in_valid),
    .hold      (hold),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .ctrl_o    (ctrl_o),
    .valid_o   (valid_o),
    .bubble_cnt(bubble_cnt),
    .hold_err  (hold_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]        in_ctrl;
    logic                    in_valid;
    logic [NSTAGE-1:0]       hold;
    logic [NSTAGE-1:0]       flush;
    logic                    cnt_clr;
    logic [NSTAGE*WIDTH-1:0] exp_ctrl;
    logic [NSTAGE-1:0]       exp_valid;
    logic [CNTW-1:0]         exp_cnt;
    logic                    exp_err;
  } vec_t;

  vec_t vecs[9];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [NSTAGE*WIDTH-1:0] ec,
                           input logic [NSTAGE-1:0] ev, input logic [CNTW-1:0] en,
                           input logic ee);
    check({tag, ".ctrl"}, 32'(ctrl_o), 32'(ec));
    check({tag, ".valid"}, 32'(valid_o), 32'(ev));
    check({tag, ".cnt"}, 32'(bubble_cnt), 32'(en));
    check({tag, ".err"}, 32'(hold_err), 32'(ee));
  endtask

  task automatic step(input logic [WIDTH-1:0] c, input logic v, input logic [NSTAGE-1:0] h,
                      input logic [NSTAGE-1:0] f, input logic clr);
    in_ctrl  = c;
    in_valid = v;
    hold     = h;
    flush    = f;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    // ctrl expectations are {stage2, stage1, stage0}
    vecs[0] = '{8'h11, 1'b1, 3'b000, 3'b000, 1'b0, 24'h00_00_11, 3'b001, 4'd0, 1'b0};
    vecs[1] = '{8'h22, 1'b1, 3'b000, 3'b000, 1'b0, 24'h00_11_22, 3'b011, 4'd0, 1'b0};
    vecs[2] = '{8'h33, 1'b1, 3'b000, 3'b000, 1'b0, 24'h11_22_33, 3'b111, 4'd0, 1'b0};
    vecs[3] = '{8'h44, 1'b1, 3'b001, 3'b000, 1'b0, 24'h22_00_33, 3'b101, 4'd1, 1'b0};
    vecs[4] = '{8'h44, 1'b1, 3'b000, 3'b000, 1'b0, 24'h00_33_44, 3'b011, 4'd1, 1'b0};
    vecs[5] = '{8'h55, 1'b1, 3'b011, 3'b010, 1'b0, 24'h00_00_44, 3'b001, 4'd2, 1'b0};
    vecs[6] = '{8'hAA, 1'b0, 3'b000, 3'b000, 1'b0, 24'h00_44_AA, 3'b010, 4'd2, 1'b0};
    vecs[7] = '{8'h66, 1'b1, 3'b010, 3'b000, 1'b0, 24'h00_44_66, 3'b011, 4'd3, 1'b1};
    vecs[8] = '{8'h77, 1'b1, 3'b000, 3'b000, 1'b0, 24'h44_66_77, 3'b111, 4'd3, 1'b1};

    reset    = 1'b0;
    in_ctrl  = '0;
    in_valid = 1'b0;
    hold     = '0;
    flush    = '0;
    cnt_clr  = 1'b0;
    #12;
    check_all("reset", 24'h0, 3'b000, 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].in_ctrl, vecs[i].in_valid, vecs[i].hold, vecs[i].flush, vecs[i].cnt_clr);
      check_all($sformatf("vec%0d", i), vecs[i].exp_ctrl, vecs[i].exp_valid,
                vecs[i].exp_cnt, vecs[i].exp_err);
    end

    // Saturation: counter is at 3, so 12 flush edges reach 15 and further edges hold it.
    for (int i = 1; i <= 20; i++) begin
      step(8'h88, 1'b1, 3'b000, 3'b001, 1'b0);
      if (i == 11) check("cnt_pre_sat", 32'(bubble_cnt), 32'd14);
      if (i == 12) check("cnt_at_sat", 32'(bubble_cnt), 32'd15);
    end
    check("cnt_sat_hold", 32'(bubble_cnt), 32'd15);
    check("stage0_flushed", 32'({valid_o[0], ctrl_o[7:0]}), 32'h000);

    step(8'h88, 1'b1, 3'b000, 3'b001, 1'b1);
    check("cnt_clr_beats_inc", 32'(bubble_cnt), 32'd0);
    step(8'h88, 1'b1, 3'b000, 3'b001, 1'b0);
    check("cnt_after_clr", 32'(bubble_cnt), 32'd1);
    check("err_sticky", 32'(hold_err), 32'd1);

    // Asynchronous reset mid-stream, between clock edges.
    step(8'h5A, 1'b1, 3'b000, 3'b000, 1'b0);
    step(8'hA5, 1'b1, 3'b000, 3'b000, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 24'h0, 3'b000, 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(8'h99, 1'b1, 3'b000, 3'b000, 1'b0);
    check_all("post_reset", 24'h00_00_99, 3'b001, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
